// File: rtl/const_bits_monitor.sv
// Sink-side checker for a constant bus: registers the observed value every cycle and,
// once a settle window has elapsed, flags, counts and captures mismatches against VALUE.
module const_bits_monitor #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] VALUE     = WIDTH'(1'b1),
    parameter int               SETTLE    = 2,
    parameter int               CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    input  logic [WIDTH-1:0]     I,
    input  logic                 CE,
    input  logic                 CLR,
    output logic                 ARMED,
    output logic                 ERR,
    output logic [CNT_WIDTH-1:0] ERR_COUNT,
    output logic [WIDTH-1:0]     FIRST_BAD
);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    // Timer only has to reach SETTLE-1; keep at least one bit so SETTLE of 0 or 1 still elaborates.
    localparam int                   TW          = (SETTLE > 32'sd1) ? $clog2(SETTLE) : 32'sd1;
    localparam logic [TW-1:0]        SETTLE_LAST = TW'((SETTLE > 32'sd0) ? (SETTLE - 32'sd1) : 32'sd0);
    localparam logic [TW-1:0]        TIMER_ONE   = TW'(1'b1);
    localparam logic [TW-1:0]        TIMER_ZERO  = TW'(1'b0);
    localparam bit                   SETTLE_ZERO = (SETTLE == 32'sd0);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1'b1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = CNT_WIDTH'(1'b0);
    localparam logic [WIDTH-1:0]     BUS_ZERO    = WIDTH'(1'b0);

    function automatic logic bus_mismatch(input logic [WIDTH-1:0] smp);
        return (smp != VALUE);
    endfunction

    logic [1:0]           state_r,     state_nxt_s;
    logic [TW-1:0]        timer_r,     timer_nxt_s;
    logic [WIDTH-1:0]     sample_r;
    logic                 err_r,       err_nxt_s;
    logic [CNT_WIDTH-1:0] err_count_r, err_count_nxt_s;
    logic [WIDTH-1:0]     first_bad_r, first_bad_nxt_s;
    logic                 armed_r,     armed_nxt_s;
    logic                 mismatch_s;

    assign mismatch_s = bus_mismatch(sample_r);

    // Next-state logic: CLR beats CE, CE=0 freezes everything except the input sample.
    always_comb begin
        state_nxt_s     = state_r;
        timer_nxt_s     = timer_r;
        err_nxt_s       = err_r;
        err_count_nxt_s = err_count_r;
        first_bad_nxt_s = first_bad_r;
        if (CLR) begin
            state_nxt_s     = ST_SETTLE;
            timer_nxt_s     = TIMER_ZERO;
            err_nxt_s       = 1'b0;
            err_count_nxt_s = CNT_ZERO;
            first_bad_nxt_s = BUS_ZERO;
        end else if (CE) begin
            case (state_r)
                ST_SETTLE: begin
                    if (SETTLE_ZERO || (timer_r == SETTLE_LAST)) begin
                        state_nxt_s = ST_ARMED;
                        timer_nxt_s = TIMER_ZERO;
                    end else begin
                        timer_nxt_s = timer_r + TIMER_ONE;
                    end
                end
                ST_ARMED: begin
                    if (mismatch_s) begin
                        state_nxt_s     = ST_FAULT;
                        err_nxt_s       = 1'b1;
                        err_count_nxt_s = CNT_ONE;
                        first_bad_nxt_s = sample_r;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_FAULT: begin
                    if (mismatch_s && (err_count_r != CNT_MAX)) begin
                        err_count_nxt_s = err_count_r + CNT_ONE;
                    end else begin
                        err_count_nxt_s = err_count_r;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a fresh settle window.
                    state_nxt_s = ST_SETTLE;
                    timer_nxt_s = TIMER_ZERO;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
        armed_nxt_s = (state_nxt_s != ST_SETTLE);
    end

    // State, input sample and result registers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_r     <= ST_SETTLE;
            timer_r     <= TIMER_ZERO;
            sample_r    <= BUS_ZERO;
            err_r       <= 1'b0;
            err_count_r <= CNT_ZERO;
            first_bad_r <= BUS_ZERO;
            armed_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            sample_r    <= I;
            err_r       <= err_nxt_s;
            err_count_r <= err_count_nxt_s;
            first_bad_r <= first_bad_nxt_s;
            armed_r     <= armed_nxt_s;
        end
    end

    assign ARMED     = armed_r;
    assign ERR       = err_r;
    assign ERR_COUNT = err_count_r;
    assign FIRST_BAD = first_bad_r;

endmodule

// File: tb/tb_const_bits_monitor.sv
// Scoreboard bench for const_bits_monitor: directed scenarios then random traffic,
// each cycle's expected outputs come from a counting model and are checked at the falling edge.
module tb_const_bits_monitor;

    localparam int         WIDTH     = 8;
    localparam logic [7:0] VALUE     = 8'hA5;
    localparam int         SETTLE    = 2;
    localparam int         CNT_WIDTH = 2;
    localparam int         CNT_MAX   = 3;

    typedef struct packed {
        logic       armed;
        logic       err;
        logic [1:0] cnt;
        logic [7:0] first;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_bus;
    logic       ce;
    logic       clr;
    logic       armed;
    logic       err;
    logic [1:0] err_count;
    logic [7:0] first_bad;

    const_bits_monitor #(
        .WIDTH(WIDTH), .VALUE(VALUE), .SETTLE(SETTLE), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .CLK(clk), .ASYNCRESETN(rst_n), .I(i_bus), .CE(ce), .CLR(clr),
        .ARMED(armed), .ERR(err), .ERR_COUNT(err_count), .FIRST_BAD(first_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: CE edges since reset/CLR decide whether compares are live.
    int         m_ce_edges;
    logic [7:0] m_sample;
    bit         m_err;
    int         m_cnt;
    logic [7:0] m_first;

    task automatic model_reset();
        m_ce_edges = 0;
        m_sample   = 8'h00;
        m_err      = 1'b0;
        m_cnt      = 0;
        m_first    = 8'h00;
    endtask

    task automatic model_edge(input logic [7:0] iv, input logic cev, input logic clrv);
        if (clrv) begin
            m_ce_edges = 0;
            m_err      = 1'b0;
            m_cnt      = 0;
            m_first    = 8'h00;
        end else if (cev) begin
            if (m_ce_edges >= SETTLE && m_sample != VALUE) begin
                if (!m_err) begin
                    m_err   = 1'b1;
                    m_first = m_sample;
                end
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            if (m_ce_edges < SETTLE) m_ce_edges++;
        end
        m_sample = iv;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.armed = (m_ce_edges >= SETTLE);
        e.err   = m_err;
        e.cnt   = 2'(m_cnt);
        e.first = m_first;
        return e;
    endfunction

    // Push the outputs expected at this cycle's falling edge, then clock the model.
    task automatic cycle(input logic [7:0] iv, input logic cev, input logic clrv, input logic rstv);
        i_bus = iv;
        ce    = cev;
        clr   = clrv;
        rst_n = rstv;
        if (!rstv) model_reset();
        exp_q.push_back(model_out());
        @(posedge clk);
        if (!rstv) model_reset();
        else model_edge(iv, cev, clrv);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("armed",     {7'd0, armed},     {7'd0, e.armed});
                check("err",       {7'd0, err},       {7'd0, e.err});
                check("err_count", {6'd0, err_count}, {6'd0, e.cnt});
                check("first_bad", first_bad,         e.first);
            end
        end
    end

    initial begin
        logic [7:0] rv;
        rst_n = 1'b0;
        i_bus = 8'h00;
        ce    = 1'b0;
        clr   = 1'b0;
        model_reset();
        #1;
        repeat (3) cycle(8'h00, 1'b1, 1'b0, 1'b0);
        // Bad value sampled on the first edge falls inside the settle window.
        cycle(8'h00, 1'b1, 1'b0, 1'b1);
        repeat (20) cycle(VALUE, 1'b1, 1'b0, 1'b1);
        // Single-cycle glitch, then a sustained mismatch to hit saturation.
        cycle(8'h5A, 1'b1, 1'b0, 1'b1);
        repeat (4) cycle(VALUE, 1'b1, 1'b0, 1'b1);
        repeat (6) cycle(8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (2) cycle(VALUE, 1'b1, 1'b0, 1'b1);
        // CLR while mismatching, mismatch continues through the new settle window.
        cycle(8'h3C, 1'b1, 1'b1, 1'b1);
        repeat (4) cycle(8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (2) cycle(VALUE, 1'b1, 1'b1, 1'b1);
        repeat (5) cycle(VALUE, 1'b1, 1'b0, 1'b1);
        // CE low while mismatching: results hold, the sample still moves.
        repeat (5) cycle(8'hFF, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(VALUE, 1'b1, 1'b0, 1'b1);
        // Reset asserted mid-cycle during a fault.
        repeat (2) cycle(8'h00, 1'b1, 1'b0, 1'b0);
        repeat (4) cycle(VALUE, 1'b1, 1'b0, 1'b1);
        // Random traffic biased toward the expected constant.
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : VALUE;
            cycle(rv, ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 63) != 0));
        end
        exp_q.push_back(model_out());
        for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
